// File: rtl/output_argmax.sv
// output_argmax: argmax stage behind the zyNet classifier.
// Takes NUM_CLASSES signed logits per frame over a valid/yumi handshake.
// Reports the winning class index, or NUM_CLASSES when the winning score is
// below MIN_SCORE. The result is held until the consumer strobes yumi_i.
// Optional: define OUTPUT_ARGMAX_SCORE_EN to add score_o, the winning logit.
module output_argmax #(
    parameter int                          WORD_SIZE   = 16,
    parameter int                          INT_BITS    = 4,
    parameter int                          NUM_CLASSES = 4,
    parameter logic signed [WORD_SIZE-1:0] MIN_SCORE   = '0
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                valid_i,
    input  logic signed [WORD_SIZE-1:0]         data_i,
    output logic                                yumi_o,
    output logic                                valid_o,
    output logic [$clog2(NUM_CLASSES+1)-1:0]    class_o,
`ifdef OUTPUT_ARGMAX_SCORE_EN
    output logic signed [WORD_SIZE-1:0]         score_o,
`endif
    input  logic                                yumi_i
);

    localparam int              CLS_W = $clog2(NUM_CLASSES + 1);
    localparam logic [CLS_W-1:0] LAST  = CLS_W'(NUM_CLASSES - 1);
    localparam logic [CLS_W-1:0] REJ   = CLS_W'(NUM_CLASSES);

    // INT_BITS only documents the fixed-point format; compares use raw words.
    if (NUM_CLASSES < 2 || NUM_CLASSES > 255 || INT_BITS > WORD_SIZE) begin : g_param_chk
        $error("output_argmax: illegal parameterization");
    end

    typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_t;

    state_t                      r_state, w_state_nxt;
    logic [CLS_W-1:0]            r_idx;
    logic [CLS_W-1:0]            r_best;
    logic signed [WORD_SIZE-1:0] r_max;
    logic [CLS_W-1:0]            r_class;
    logic                        r_valid;
    logic signed [WORD_SIZE-1:0] r_score;

    logic                        w_xfer;
    logic                        w_last;
    logic                        w_take;
    logic signed [WORD_SIZE-1:0] w_new_max;
    logic [CLS_W-1:0]            w_new_best;
    logic                        w_reject;

    // First word of a frame always seeds the max; later words must beat it
    // strictly, so ties keep the lowest index.
    assign w_xfer     = yumi_o;
    assign w_last     = (r_idx == LAST);
    assign w_take     = (r_idx == '0) || (data_i > r_max);
    assign w_new_max  = w_take ? data_i : r_max;
    assign w_new_best = w_take ? r_idx : r_best;
    assign w_reject   = (w_new_max < MIN_SCORE);

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= COLLECT;
        else         r_state <= w_state_nxt;
    end

    // Next-state: finish the frame on its last transfer, rearm on consume
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: if (w_xfer && w_last) w_state_nxt = DONE;
            DONE:    if (yumi_i)           w_state_nxt = COLLECT;
            default: w_state_nxt = COLLECT;
        endcase
    end

    // Outputs: upstream is only consumed while collecting and out of reset
    always_comb begin
        yumi_o  = (r_state == COLLECT) & valid_i & ~reset_i;
        valid_o = r_valid;
        class_o = r_class;
    end

    // Running max / index tracking and result registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_idx   <= '0;
            r_best  <= '0;
            r_max   <= '0;
            r_class <= '0;
            r_valid <= 1'b0;
            r_score <= '0;
        end else if (w_xfer) begin
            r_max  <= w_new_max;
            r_best <= w_new_best;
            if (w_last) begin
                r_idx   <= '0;
                r_class <= w_reject ? REJ : w_new_best;
                r_score <= w_new_max;
                r_valid <= 1'b1;
            end else begin
                r_idx <= r_idx + CLS_W'(1);
            end
        end else if (r_valid && yumi_i) begin
            r_valid <= 1'b0;
        end
    end

`ifdef OUTPUT_ARGMAX_SCORE_EN
    assign score_o = r_score;
`else
    // Winning score is not exported in this build.
    logic w_score_unused;
    assign w_score_unused = ^r_score;
`endif

endmodule
